// File: rtl/bus_dest_router_if.sv
// Bus-side and destination-side handshake bundle for the destination router.
// master = bus source plus both destination sinks; slave = the router itself.
interface bus_dest_router_if #(
    parameter int N = 8
);
    logic [N-1:0] bus_data;
    logic         bus_valid;
    logic         bus_dest;
    logic         bus_parity;
    logic         bus_ready;
    logic [N-1:0] data_out_1;
    logic         valid_1;
    logic         ready_1;
    logic [N-1:0] data_out_2;
    logic         valid_2;
    logic         ready_2;

    modport master (
        output bus_data, bus_valid, bus_dest, bus_parity,
        input  bus_ready,
        input  data_out_1, valid_1, data_out_2, valid_2,
        output ready_1, ready_2
    );

    modport slave (
        input  bus_data, bus_valid, bus_dest, bus_parity,
        output bus_ready,
        output data_out_1, valid_1, data_out_2, valid_2,
        input  ready_1, ready_2
    );
endinterface

// File: rtl/bus_dest_router.sv
// Steers bus words into one of two FIFOs by bus_dest; 1-cycle accept-to-valid, bus_ready low
// while the addressed FIFO is full. BUS_PARITY_EN: drop and count words failing even parity.

// Generic FIFO: occupancy-tracked circular buffer, head output zeroed when empty.
module bus_dest_router_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [N-1:0]                 push_dat,
    input  logic                         pop,
    output logic [N-1:0]                 head_dat,
    output logic                         vld,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          push_en, pop_en;

    assign full     = (occ_q == OW'(DEPTH));
    assign vld      = (occ_q != '0);
    assign occ      = occ_q;
    assign head_dat = vld ? mem_q[rd_ptr_q] : '0;
    assign push_en  = push && !full;
    assign pop_en   = pop && vld;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module bus_dest_router #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    bus_dest_router_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]   occ_1,
    output logic [$clog2(DEPTH+1)-1:0]   occ_2,
    output logic [ERR_W-1:0]             err_count
);
    logic             full_1, full_2;
    logic             accept, par_bad, wr_en;
    logic             push_1, push_2;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    // Readiness looks only at the addressed FIFO; a same-cycle pop does not free a slot.
    assign bus.bus_ready = !rst && !(bus.bus_dest ? full_2 : full_1);
    assign accept        = bus.bus_valid && bus.bus_ready;
    assign par_bad       = ^{bus.bus_data, bus.bus_parity};

`ifdef BUS_PARITY_EN
    assign wr_en = accept && !par_bad;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && par_bad && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end
`else
    logic unused_par_bad;
    assign unused_par_bad = par_bad;
    assign wr_en          = accept;

    always_comb begin
        err_count_d = '0;
    end
`endif

    assign push_1    = wr_en && !bus.bus_dest;
    assign push_2    = wr_en &&  bus.bus_dest;
    assign err_count = err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    bus_dest_router_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_1 (
        .clk      (clk),
        .rst      (rst),
        .push     (push_1),
        .push_dat (bus.bus_data),
        .pop      (bus.ready_1),
        .head_dat (bus.data_out_1),
        .vld      (bus.valid_1),
        .full     (full_1),
        .occ      (occ_1)
    );

    bus_dest_router_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_2 (
        .clk      (clk),
        .rst      (rst),
        .push     (push_2),
        .push_dat (bus.bus_data),
        .pop      (bus.ready_2),
        .head_dat (bus.data_out_2),
        .vld      (bus.valid_2),
        .full     (full_2),
        .occ      (occ_2)
    );
endmodule

// File: tb/tb_bus_dest_router.sv
// Table of directed vectors plus random traffic, all checked against a per-destination queue model.
module tb_bus_dest_router;
    localparam int N     = 8;
    localparam int DEPTH = 4;
`ifdef BUS_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] occ_1, occ_2;
    logic [7:0] err_count;

    bus_dest_router_if #(.N(N)) bif ();

    bus_dest_router #(.N(N), .DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .occ_1     (occ_1),
        .occ_2     (occ_2),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    int         err_m = 0;
    bit         known = 1'b0;

    typedef struct {
        bit         r, v, d;
        logic [7:0] dat;
        bit         bad, r1, r2, e_rdy;
        int         e_o1, e_o2;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mkv(input bit r, v, d, input logic [7:0] dat, input bit bad, r1, r2,
                                 input bit e_rdy, input int e_o1, e_o2);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.dat = dat; x.bad = bad; x.r1 = r1; x.r2 = r2;
        x.e_rdy = e_rdy; x.e_o1 = e_o1; x.e_o2 = e_o2;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive after negedge, check combinational/head outputs, model the edge, check state.
    task automatic step(input bit r, v, d, input logic [7:0] dat, input bit bad, r1, r2,
                        output bit rdy_seen);
        bit exp_rdy;
        rst            = r;
        bif.bus_valid  = v;
        bif.bus_dest   = d;
        bif.bus_data   = dat;
        bif.bus_parity = (^dat) ^ bad;
        bif.ready_1    = r1;
        bif.ready_2    = r2;
        #2;
        exp_rdy  = !r && ((d ? q2.size() : q1.size()) < DEPTH);
        rdy_seen = bif.bus_ready;
        chk("bus_ready", bif.bus_ready, exp_rdy);
        if (known) begin
            chk("valid_1", bif.valid_1, q1.size() != 0);
            chk("data_out_1", bif.data_out_1, (q1.size() != 0) ? q1[0] : 8'h00);
            chk("valid_2", bif.valid_2, q2.size() != 0);
            chk("data_out_2", bif.data_out_2, (q2.size() != 0) ? q2[0] : 8'h00);
        end
        @(posedge clk);
        if (r) begin
            q1.delete();
            q2.delete();
            err_m = 0;
            known = 1'b1;
        end else begin
            if (r1 && q1.size() != 0) void'(q1.pop_front());
            if (r2 && q2.size() != 0) void'(q2.pop_front());
            if (v && exp_rdy) begin
                if (PAR_EN && bad) begin
                    if (err_m < 255) err_m++;
                end else if (d) begin
                    q2.push_back(dat);
                end else begin
                    q1.push_back(dat);
                end
            end
        end
        @(negedge clk);
        chk("occ_1", occ_1, q1.size());
        chk("occ_2", occ_2, q2.size());
        chk("err_count", err_count, err_m);
    endtask

    initial begin
        bit rdy;
        // reset, single words to each destination
        tbl.push_back(mkv(0,1,0,8'hA2,0,1,1, 1, 1,0));
        tbl.push_back(mkv(0,1,1,8'h9C,0,1,1, 1, 0,1));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 0,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 0,0));
        // fill FIFO 1, overflow attempt, drain with wrap
        tbl.push_back(mkv(0,1,0,8'h01,0,0,1, 1, 1,0));
        tbl.push_back(mkv(0,1,0,8'h02,0,0,1, 1, 2,0));
        tbl.push_back(mkv(0,1,0,8'h03,0,0,1, 1, 3,0));
        tbl.push_back(mkv(0,1,0,8'h04,0,0,1, 1, 4,0));
        tbl.push_back(mkv(0,1,0,8'h05,0,0,1, 0, 4,0));
        tbl.push_back(mkv(0,1,0,8'h05,0,1,1, 0, 3,0));
        tbl.push_back(mkv(0,1,0,8'h05,0,1,1, 1, 3,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 2,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 1,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 0,0));
        // simultaneous push and pop on FIFO 1
        tbl.push_back(mkv(0,1,0,8'h11,0,0,1, 1, 1,0));
        tbl.push_back(mkv(0,1,0,8'h22,0,0,1, 1, 2,0));
        tbl.push_back(mkv(0,1,0,8'h54,0,1,1, 1, 2,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 1,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 0,0));
        // FIFO 1 full and stalled, FIFO 2 still accepts
        tbl.push_back(mkv(0,1,0,8'h31,0,0,0, 1, 1,0));
        tbl.push_back(mkv(0,1,0,8'h32,0,0,0, 1, 2,0));
        tbl.push_back(mkv(0,1,0,8'h33,0,0,0, 1, 3,0));
        tbl.push_back(mkv(0,1,0,8'h34,0,0,0, 1, 4,0));
        tbl.push_back(mkv(0,1,1,8'h90,0,0,0, 1, 4,1));
        tbl.push_back(mkv(0,0,0,8'h00,0,0,0, 0, 4,1));
        // reset with words queued and a bus word offered
        tbl.push_back(mkv(1,1,1,8'h77,0,1,1, 0, 0,0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 0,0));
        // bad then good parity
        tbl.push_back(mkv(0,1,0,8'hA2,1,0,1, 1, PAR_EN ? 0 : 1, 0));
        tbl.push_back(mkv(0,1,0,8'hA2,0,0,1, 1, PAR_EN ? 1 : 2, 0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, PAR_EN ? 0 : 1, 0));
        tbl.push_back(mkv(0,0,0,8'h00,0,1,1, 1, 0,0));

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, rdy);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].dat, tbl[i].bad, tbl[i].r1, tbl[i].r2, rdy);
            chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_occ_1", i), occ_1, tbl[i].e_o1);
            chk($sformatf("tbl%0d_occ_2", i), occ_2, tbl[i].e_o2);
        end

        // error counter saturation
        repeat (260) step(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, rdy);
        chk("err_saturated", err_count, PAR_EN ? 8'd255 : 8'd0);

        // random traffic with occasional parity errors and backpressure
        repeat (400) begin
            step(1'b0, 1'($urandom % 4 != 0), 1'($urandom % 2), 8'($urandom),
                 1'($urandom % 8 == 0), 1'($urandom % 4 != 0), 1'($urandom % 3 != 0), rdy);
        end
        repeat (6) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, rdy);
        chk("drained_occ_1", occ_1, 0);
        chk("drained_occ_2", occ_2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
